target_req_arbiter: RTL and testbench

TARGET_REQ_ARBITER -- requirements
Module: target_req_arbiter

---
 rtl/i3c_pkg.sv | 19 +
 rtl/bus_avail_timer.sv | 35 +++
 rtl/target_req_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_target_req_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i3c_pkg.sv
// Shared I3C target types: request-arbiter states, request kinds
// and the broadcast Hot-Join address.
package i3c_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_AVAIL,
    ST_REQUEST,
    ST_WAIT_RES
  } target_req_arb_state_e;

  typedef enum logic {
    KIND_IBI,
    KIND_HJ
  } req_kind_e;

  localparam logic [6:0] HotJoinAddr = 7'h02;

endpackage

// File: rtl/bus_avail_timer.sv
// Saturating bus-available counter; avail_o is high on the idle cycle
// in which the count has already reached the threshold.
module bus_avail_timer #(
  parameter int CntW = 20
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            run_i,
  input  logic            bus_idle_i,
  input  logic [CntW-1:0] thr_i,
  output logic            avail_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!run_i || !bus_idle_i) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign avail_o = run_i & bus_idle_i & (cnt_q >= thr_i);

endmodule

// File: rtl/target_req_arbiter.sv
// I3C target IBI / Hot-Join bus-request arbiter with retry on lost
// address arbitration. Hot-Join path enabled by I3C_TARGET_HOT_JOIN_EN.
module target_req_arbiter
  import i3c_pkg::*;
#(
  parameter int MaxRetries = 3,
  parameter int CntW       = 20
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            enable_i,
  input  logic            bus_idle_i,
  input  logic [CntW-1:0] t_bus_available_i,
  input  logic            dyn_addr_valid_i,
  input  logic [6:0]      ibi_addr_i,
  input  logic            hj_req_i,
  input  logic            ibi_req_i,
  output logic            req_valid_o,
  input  logic            req_ready_i,
  output logic [6:0]      req_addr_o,
  output logic            req_hj_o,
  input  logic            xfer_done_i,
  input  logic            arb_lost_i,
  output logic            hj_done_o,
  output logic            ibi_done_o,
  output logic            hj_fail_o,
  output logic            ibi_fail_o,
  output logic            busy_o,
  output logic [1:0]      retry_cnt_o
);

  target_req_arb_state_e state_q, state_d;
  req_kind_e  kind_q, kind_d;
  logic [6:0] addr_q, addr_d;
  logic [1:0] retry_q, retry_d;
  logic [2:0] retry_inc;
  logic       ibi_pend_q, ibi_pend_d;
  logic       ibi_done_q, ibi_done_d;
  logic       ibi_fail_q, ibi_fail_d;
  logic       hj_elig, ibi_elig, any_elig;
  logic       avail;
  logic       done_c, fail_c, clr_c, drop_c;

  bus_avail_timer #(
    .CntW(CntW)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .run_i     (enable_i && state_q == ST_WAIT_AVAIL),
    .bus_idle_i(bus_idle_i),
    .thr_i     (t_bus_available_i),
    .avail_o   (avail)
  );

  assign ibi_elig  = ibi_pend_q & dyn_addr_valid_i;
  assign any_elig  = hj_elig | ibi_elig;
  assign retry_inc = {1'b0, retry_q} + 3'd1;

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    addr_d  = addr_q;
    retry_d = retry_q;
    done_c  = 1'b0;
    fail_c  = 1'b0;
    clr_c   = 1'b0;
    drop_c  = 1'b0;
    if (!enable_i) begin
      state_d = ST_IDLE;
      retry_d = '0;
      drop_c  = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (any_elig) state_d = ST_WAIT_AVAIL;
        end
        ST_WAIT_AVAIL: begin
          if (!any_elig) begin
            state_d = ST_IDLE;
          end else if (avail) begin
            state_d = ST_REQUEST;
            kind_d  = hj_elig ? KIND_HJ : KIND_IBI;
            addr_d  = hj_elig ? HotJoinAddr : ibi_addr_i;
          end
        end
        ST_REQUEST: begin
          if (req_ready_i) state_d = ST_WAIT_RES;
        end
        ST_WAIT_RES: begin
          if (xfer_done_i) begin
            done_c  = 1'b1;
            clr_c   = 1'b1;
            retry_d = '0;
            state_d = ST_IDLE;
          end else if (arb_lost_i) begin
            if (int'(retry_inc) >= MaxRetries) begin
              fail_c  = 1'b1;
              clr_c   = 1'b1;
              retry_d = '0;
              state_d = ST_IDLE;
            end else begin
              retry_d = retry_inc[1:0];
              state_d = ST_WAIT_AVAIL;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // Selection only lives while a request is in flight
    if (state_d == ST_IDLE || state_d == ST_WAIT_AVAIL) begin
      addr_d = '0;
      kind_d = KIND_IBI;
    end
  end

  always_comb begin
    ibi_pend_d = ibi_req_i |
                 (ibi_pend_q & ~(drop_c | (clr_c & kind_q == KIND_IBI)));
    ibi_done_d = done_c & (kind_q == KIND_IBI);
    ibi_fail_d = fail_c & (kind_q == KIND_IBI);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      kind_q     <= KIND_IBI;
      addr_q     <= '0;
      retry_q    <= '0;
      ibi_pend_q <= 1'b0;
      ibi_done_q <= 1'b0;
      ibi_fail_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      addr_q     <= addr_d;
      retry_q    <= retry_d;
      ibi_pend_q <= ibi_pend_d;
      ibi_done_q <= ibi_done_d;
      ibi_fail_q <= ibi_fail_d;
    end
  end

`ifdef I3C_TARGET_HOT_JOIN_EN
  logic hj_pend_q, hj_pend_d;
  logic hj_done_q, hj_done_d;
  logic hj_fail_q, hj_fail_d;
  logic hj_hold, hj_clr;

  // An HJ already on the bus survives a late dynamic address
  assign hj_hold = (state_q == ST_REQUEST || state_q == ST_WAIT_RES) &&
                   kind_q == KIND_HJ;
  assign hj_clr  = drop_c | (clr_c & kind_q == KIND_HJ) |
                   (dyn_addr_valid_i & ~hj_hold);
  assign hj_elig = hj_pend_q & ~dyn_addr_valid_i;

  always_comb begin
    hj_pend_d = hj_req_i | (hj_pend_q & ~hj_clr);
    hj_done_d = done_c & (kind_q == KIND_HJ);
    hj_fail_d = fail_c & (kind_q == KIND_HJ);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hj_pend_q <= 1'b0;
      hj_done_q <= 1'b0;
      hj_fail_q <= 1'b0;
    end else begin
      hj_pend_q <= hj_pend_d;
      hj_done_q <= hj_done_d;
      hj_fail_q <= hj_fail_d;
    end
  end

  assign hj_done_o = hj_done_q;
  assign hj_fail_o = hj_fail_q;
  assign req_hj_o  = (kind_q == KIND_HJ);
`else
  logic unused_hj;
  assign unused_hj = hj_req_i;
  assign hj_elig   = 1'b0;
  assign hj_done_o = 1'b0;
  assign hj_fail_o = 1'b0;
  assign req_hj_o  = 1'b0;
`endif

  assign req_valid_o = (state_q == ST_REQUEST);
  assign busy_o      = (state_q != ST_IDLE);
  assign req_addr_o  = addr_q;
  assign retry_cnt_o = retry_q;
  assign ibi_done_o  = ibi_done_q;
  assign ibi_fail_o  = ibi_fail_q;

endmodule

// File: tb/tb_target_req_arbiter.sv
// Directed + randomized bench for target_req_arbiter; expected latencies
// and retry outcomes come from a cycle-count model of the request rules.
module tb_target_req_arbiter;

  localparam int MaxR = 3;
  localparam int CW   = 20;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          enable_i;
  logic          bus_idle_i;
  logic [CW-1:0] t_bus_available_i;
  logic          dyn_addr_valid_i;
  logic [6:0]    ibi_addr_i;
  logic          hj_req_i;
  logic          ibi_req_i;
  logic          req_valid_o;
  logic          req_ready_i;
  logic [6:0]    req_addr_o;
  logic          req_hj_o;
  logic          xfer_done_i;
  logic          arb_lost_i;
  logic          hj_done_o, ibi_done_o;
  logic          hj_fail_o, ibi_fail_o;
  logic          busy_o;
  logic [1:0]    retry_cnt_o;

  int vectors     = 0;
  int miscompares = 0;

  target_req_arbiter #(
    .MaxRetries(MaxR),
    .CntW      (CW)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .enable_i         (enable_i),
    .bus_idle_i       (bus_idle_i),
    .t_bus_available_i(t_bus_available_i),
    .dyn_addr_valid_i (dyn_addr_valid_i),
    .ibi_addr_i       (ibi_addr_i),
    .hj_req_i         (hj_req_i),
    .ibi_req_i        (ibi_req_i),
    .req_valid_o      (req_valid_o),
    .req_ready_i      (req_ready_i),
    .req_addr_o       (req_addr_o),
    .req_hj_o         (req_hj_o),
    .xfer_done_i      (xfer_done_i),
    .arb_lost_i       (arb_lost_i),
    .hj_done_o        (hj_done_o),
    .ibi_done_o       (ibi_done_o),
    .hj_fail_o        (hj_fail_o),
    .ibi_fail_o       (ibi_fail_o),
    .busy_o           (busy_o),
    .retry_cnt_o      (retry_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp,
                     input string tag);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue_ibi(input logic [6:0] a);
    ibi_addr_i = a;
    ibi_req_i  = 1'b1;
    step();
    ibi_req_i  = 1'b0;
  endtask

  // lead: cycles before counting starts; j: waiting-cycle index with bus busy
  task automatic wait_req(input int lead, input int t, input int j,
                          input logic [6:0] ea, input logic eh,
                          input string tag);
    int n;
    int exp_lat;
    n = 0;
    exp_lat = lead + ((j >= 0) ? j + 1 : 0) + t + 1;
    while (!req_valid_o && n < 200) begin
      bus_idle_i = (j >= 0 && n == lead + j) ? 1'b0 : 1'b1;
      step();
      n++;
    end
    bus_idle_i = 1'b1;
    chk(n, exp_lat, {tag, "_latency"});
    chk(req_addr_o, ea, {tag, "_addr"});
    chk(req_hj_o, eh, {tag, "_kind"});
  endtask

  task automatic accept;
    req_ready_i = 1'b1;
    step();
    req_ready_i = 1'b0;
    chk(req_valid_o, 0, "accept_valid_drop");
    chk(busy_o, 1, "accept_busy");
  endtask

  task automatic resolve(input bit d, input bit l, input int nret,
                         output bit fin);
    bit ed, ef;
    int er;
    ed  = d;
    ef  = !d && (nret + 1 >= MaxR);
    er  = (ed || ef) ? 0 : nret + 1;
    fin = ed || ef;
    xfer_done_i = d;
    arb_lost_i  = l;
    step();
    xfer_done_i = 1'b0;
    arb_lost_i  = 1'b0;
    chk(ibi_done_o, ed, "res_done");
    chk(ibi_fail_o, ef, "res_fail");
    chk(retry_cnt_o, er, "res_retry");
    chk(busy_o, !fin, "res_busy");
    if (fin) begin
      step();
      chk({ibi_done_o, ibi_fail_o}, 0, "res_pulse_width");
      chk(busy_o, 0, "res_idle");
    end
  endtask

  int         t, j, nret;
  bit         fin, d, l;
  logic [6:0] a;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    enable_i = 1'b1;
    bus_idle_i = 1'b1;
    t_bus_available_i = '0;
    dyn_addr_valid_i = 1'b1;
    ibi_addr_i = '0;
    hj_req_i = 1'b0;
    ibi_req_i = 1'b0;
    req_ready_i = 1'b0;
    xfer_done_i = 1'b0;
    arb_lost_i = 1'b0;
    step();
    step();
    chk({req_valid_o, req_addr_o, req_hj_o, hj_done_o, ibi_done_o,
         hj_fail_o, ibi_fail_o, busy_o, retry_cnt_o}, 0, "reset_outputs");
    rst_i = 1'b0;
    step();
    chk(busy_o, 0, "post_reset_idle");

    // Threshold 0 leaves after one idle cycle
    t_bus_available_i = 20'd0;
    issue_ibi(7'h15);
    wait_req(1, 0, -1, 7'h15, 1'b0, "thr0");
    accept();
    resolve(1'b1, 1'b0, 0, fin);

    // Bus busy at count 5, threshold 10, then request held unaccepted
    t_bus_available_i = 20'd10;
    issue_ibi(7'h31);
    wait_req(1, 10, 5, 7'h31, 1'b0, "busy_restart");
    ibi_addr_i = 7'h4e;
    for (int k = 0; k < 20; k++) begin
      step();
      chk(req_valid_o, 1, "hold_valid");
      chk(req_addr_o, 7'h31, "hold_addr");
    end
    accept();
    resolve(1'b1, 1'b0, 0, fin);

    // Three lost arbitrations exhaust the retries
    t_bus_available_i = 20'd2;
    issue_ibi(7'h44);
    wait_req(1, 2, -1, 7'h44, 1'b0, "retry_first");
    for (int k = 0; k < MaxR; k++) begin
      accept();
      resolve(1'b0, 1'b1, k, fin);
      if (!fin) wait_req(0, 2, -1, 7'h44, 1'b0, "retry_again");
    end
    chk(fin, 1, "retry_exhausted");

    // Done and lost together: done wins
    issue_ibi(7'h27);
    wait_req(1, 2, -1, 7'h27, 1'b0, "both");
    accept();
    resolve(1'b0, 1'b1, 0, fin);
    wait_req(0, 2, -1, 7'h27, 1'b0, "both_retry");
    accept();
    resolve(1'b1, 1'b1, 1, fin);

    // Enable drop in WAIT_RES
    issue_ibi(7'h5a);
    wait_req(1, 2, -1, 7'h5a, 1'b0, "endrop");
    accept();
    enable_i = 1'b0;
    step();
    chk(busy_o, 0, "endrop_idle");
    chk({ibi_done_o, ibi_fail_o, hj_done_o, hj_fail_o}, 0, "endrop_pulse");
    chk(retry_cnt_o, 0, "endrop_retry");
    enable_i = 1'b1;
    repeat (4) step();
    chk(busy_o, 0, "endrop_pend_cleared");

    // Asynchronous reset in REQUEST
    issue_ibi(7'h66);
    wait_req(1, 2, -1, 7'h66, 1'b0, "rst_mid");
    #2;
    rst_i = 1'b1;
    #1;
    chk({req_valid_o, req_addr_o, req_hj_o, hj_done_o, ibi_done_o,
         hj_fail_o, ibi_fail_o, busy_o, retry_cnt_o}, 0, "rst_mid_outputs");
    step();
    rst_i = 1'b0;
    repeat (3) step();
    chk(busy_o, 0, "rst_mid_pend_cleared");

    // Hot-Join path
    dyn_addr_valid_i = 1'b0;
    t_bus_available_i = 20'd10;
    hj_req_i = 1'b1;
    step();
    hj_req_i = 1'b0;
`ifdef I3C_TARGET_HOT_JOIN_EN
    wait_req(1, 10, -1, 7'h02, 1'b1, "hj");
    accept();
    xfer_done_i = 1'b1;
    step();
    xfer_done_i = 1'b0;
    chk({hj_done_o, ibi_done_o}, 2'b10, "hj_done");
    step();
    chk(hj_done_o, 0, "hj_done_width");
    chk(busy_o, 0, "hj_idle");
`else
    for (int k = 0; k < 20; k++) begin
      step();
      chk({busy_o, req_valid_o, req_hj_o, hj_done_o, hj_fail_o}, 0,
          "hj_ignored");
    end
`endif
    dyn_addr_valid_i = 1'b1;
    step();

    // Randomized IBI transactions against the retry model
    for (int it = 0; it < 10; it++) begin
      t = $urandom_range(0, 12);
      a = 7'($urandom);
      j = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, t)) : -1;
      t_bus_available_i = CW'(t);
      issue_ibi(a);
      wait_req(1, t, j, a, 1'b0, "rnd");
      nret = 0;
      fin = 1'b0;
      while (!fin) begin
        accept();
        d = ($urandom_range(0, 3) == 0);
        l = !d || ($urandom_range(0, 1) == 1);
        resolve(d, l, nret, fin);
        if (!fin) begin
          nret++;
          wait_req(0, t, -1, a, 1'b0, "rnd_retry");
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
